// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder
//   Measures the high time of a servo PWM pulse in microseconds, range-checks
//   it, and maps accepted widths to a 4-bit position code. It also flags loss
//   of signal when rising edges stop arriving.
//
// Ports
//   sysclk    in   system clock, rising-edge active
//   reset     in   asynchronous active-high reset
//   Pulse_In  in   servo PWM input, asynchronous to sysclk
//   Width_us  out  last accepted high time in us
//   Position  out  last accepted position code
//   Valid     out  one-cycle strobe: Width_us/Position just updated
//   Err       out  one-cycle strobe: a pulse was rejected for its width
//   Lost      out  level: no rising edge seen within TIMEOUT_US
module servo_pulse_decoder #(
  parameter int unsigned TICKS_PER_US = 100,
  parameter int unsigned MIN_US       = 500,
  parameter int unsigned MAX_US       = 2500,
  parameter int unsigned TIMEOUT_US   = 25000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        Pulse_In,
  output logic [11:0] Width_us,
  output logic [3:0]  Position,
  output logic        Valid,
  output logic        Err,
  output logic        Lost
);

  localparam int unsigned PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_US + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_US - 1);
  localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT_US);
  localparam logic [11:0]   MIN_W      = 12'(MIN_US);
  localparam logic [11:0]   MAX_W      = 12'(MAX_US);
  localparam logic [11:0]   POS_BASE   = 12'd1000;
  localparam logic [11:0]   WIDTH_SAT  = 12'hFFF;

  typedef enum logic [1:0] {
    SYNC,
    WAIT_RISE,
    MEASURE
  } state_e;

  state_e state_q, state_d;

  // Input synchronizer, edge-detect delay and synchronizer-fill tracker
  logic          sync1_q, sync2_q, pulse_d1_q;
  logic [1:0]    fill_q;
  logic          pulse_s, rise, fall;

  // Measurement datapath
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   width_q, width_d;
  logic          presc_wrap;
  logic [11:0]   width_final;
  logic          in_range;
  logic [11:0]   pos_diff;
  logic [3:0]    pos_code;

  // Loss-of-signal timer
  logic [PW-1:0] tpre_q, tpre_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Output registers
  logic [11:0]   width_out_q, width_out_d;
  logic [3:0]    pos_q, pos_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          lost_q, lost_d;

  // FSM output decodes
  logic          meas_clear, meas_count, meas_done;

  assign pulse_s = sync2_q;
  assign rise    = pulse_s & ~pulse_d1_q;
  assign fall    = ~pulse_s & pulse_d1_q;

  // Synchronizer and edge-detect pipeline
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      pulse_d1_q <= 1'b0;
      fill_q     <= '0;
    end else begin
      sync1_q    <= Pulse_In;
      sync2_q    <= sync1_q;
      pulse_d1_q <= sync2_q;
      fill_q     <= {fill_q[0], 1'b1};
    end
  end

  // FSM: state register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state_q <= SYNC;
    else       state_q <= state_d;
  end

  // FSM: next state. SYNC waits until the synchronizer holds real input
  // samples (fill_q[1]); the reset zeros would otherwise look like a low
  // level and let a pulse already high at reset exit be measured.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:      if (fill_q[1] && !pulse_s) state_d = WAIT_RISE;
      WAIT_RISE: if (rise)                  state_d = MEASURE;
      MEASURE:   if (fall)                  state_d = WAIT_RISE;
      default:                              state_d = SYNC;
    endcase
  end

  // FSM: output decodes
  always_comb begin
    meas_clear = 1'b0;
    meas_count = 1'b0;
    meas_done  = 1'b0;
    unique case (state_q)
      WAIT_RISE: meas_clear = rise;
      MEASURE: begin
        meas_count = 1'b1;
        meas_done  = fall;
      end
      default: ;
    endcase
  end

  // The falling-edge cycle still owes one prescaler tick; folding its wrap in
  // combinationally makes the result floor(high_cycles / TICKS_PER_US).
  always_comb begin
    presc_wrap  = (presc_q == PRESC_LAST);
    width_final = width_q;
    if (presc_wrap && (width_q != WIDTH_SAT)) width_final = width_q + 12'd1;

    in_range = (width_final >= MIN_W) && (width_final <= MAX_W);

    pos_diff = width_final - POS_BASE;
    if (width_final < POS_BASE)      pos_code = 4'd0;
    else if ((pos_diff >> 6) > 12'd15) pos_code = 4'hF;
    else                              pos_code = pos_diff[9:6];
  end

  // Datapath next-state
  always_comb begin
    presc_d     = presc_q;
    width_d     = width_q;
    tpre_d      = tpre_q;
    to_cnt_d    = to_cnt_q;
    width_out_d = width_out_q;
    pos_d       = pos_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    lost_d      = lost_q;

    if (meas_clear) begin
      presc_d = '0;
      width_d = '0;
    end else if (meas_count) begin
      presc_d = presc_wrap ? '0 : presc_q + PW'(1);
      width_d = width_final;
    end

    if (meas_done) begin
      valid_d = in_range;
      err_d   = ~in_range;
    end

    if (valid_d) begin
      width_out_d = width_final;
      pos_d       = pos_code;
    end

    // Loss-of-signal timer: restarted by every rise, saturates at the limit
    if (rise) begin
      tpre_d   = '0;
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LIMIT) begin
      if (tpre_q == PRESC_LAST) begin
        tpre_d   = '0;
        to_cnt_d = to_cnt_q + TW'(1);
      end else begin
        tpre_d   = tpre_q + PW'(1);
      end
    end

    // Lost is sticky until an accepted pulse; rejected pulses leave it set
    if (to_cnt_q == TO_LIMIT) lost_d = 1'b1;
    if (valid_d)              lost_d = 1'b0;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      width_q     <= '0;
      tpre_q      <= '0;
      to_cnt_q    <= '0;
      width_out_q <= '0;
      pos_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      width_q     <= width_d;
      tpre_q      <= tpre_d;
      to_cnt_q    <= to_cnt_d;
      width_out_q <= width_out_d;
      pos_q       <= pos_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      lost_q      <= lost_d;
    end
  end

  assign Width_us = width_out_q;
  assign Position = pos_q;
  assign Valid    = valid_q;
  assign Err      = err_q;
  assign Lost     = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder. Uses a scaled-down clock rate and timeout
// so that every scenario fits in a short simulation.
module tb_servo_pulse_decoder;

  localparam int T    = 2;      // sysclk cycles per us
  localparam int MIN  = 500;
  localparam int MAX  = 2500;
  localparam int TO   = 2700;   // timeout in us
  localparam int GAP  = 50 * T; // low time between pulses, in cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        pin;
  logic [11:0] wus;
  logic [3:0]  pos;
  logic        vld, err, lost;

  int n_checks = 0;
  int n_pass   = 0;

  int valid_cnt = 0, err_cnt = 0, both_cnt = 0, lost_with_valid = 0;

  // Reference state: last accepted width and its position code
  int exp_w = 0;
  int exp_p = 0;

  servo_pulse_decoder #(
    .TICKS_PER_US(T),
    .MIN_US      (MIN),
    .MAX_US      (MAX),
    .TIMEOUT_US  (TO)
  ) dut (
    .sysclk  (clk),
    .reset   (rst),
    .Pulse_In(pin),
    .Width_us(wus),
    .Position(pos),
    .Valid   (vld),
    .Err     (err),
    .Lost    (lost)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (vld)         valid_cnt++;
    if (err)         err_cnt++;
    if (vld && err)  both_cnt++;
    if (vld && lost) lost_with_valid++;
  end

  function automatic int model_width(input int hi_cycles);
    int w;
    w = hi_cycles / T;
    return (w > 4095) ? 4095 : w;
  endfunction

  function automatic int model_pos(input int w);
    int p;
    if (w < 1000) return 0;
    p = (w - 1000) / 64;
    return (p > 15) ? 15 : p;
  endfunction

  // Advance the reference model for one pulse of hi_cycles sysclk cycles
  task automatic model_pulse(input int hi_cycles, output int exp_dv, output int exp_de);
    int w;
    w = model_width(hi_cycles);
    if (w >= MIN && w <= MAX) begin
      exp_dv = 1; exp_de = 0;
      exp_w  = w;
      exp_p  = model_pos(w);
    end else begin
      exp_dv = 0; exp_de = 1;
    end
  endtask

  task automatic drive_pulse(input int hi, input int lo, output int dv, output int de);
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    @(negedge clk) pin = 1'b1;
    repeat (hi) @(negedge clk);
    pin = 1'b0;
    repeat (lo) @(negedge clk);
    dv = valid_cnt - v0;
    de = err_cnt - e0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pin = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (wus !== 12'd0) $display("FAIL reset_width: got %0d expected 0", wus); else n_pass++;
    n_checks++; if (pos !== 4'd0)  $display("FAIL reset_pos: got %0d expected 0", pos); else n_pass++;
    n_checks++; if (vld !== 1'b0)  $display("FAIL reset_valid: got %b expected 0", vld); else n_pass++;
    n_checks++; if (err !== 1'b0)  $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (lost !== 1'b0) $display("FAIL reset_lost: got %b expected 0", lost); else n_pass++;
    rst = 1'b0;
    exp_w = 0; exp_p = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nominal;
    int dv, de, edv, ede;
    for (int i = 0; i < 2; i++) begin
      model_pulse(1500 * T, edv, ede);
      drive_pulse(1500 * T, GAP, dv, de);
      n_checks++; if (dv !== edv) $display("FAIL nominal_valid[%0d]: got %0d expected %0d", i, dv, edv); else n_pass++;
      n_checks++; if (de !== ede) $display("FAIL nominal_err[%0d]: got %0d expected %0d", i, de, ede); else n_pass++;
      n_checks++; if (int'(wus) !== exp_w) $display("FAIL nominal_width[%0d]: got %0d expected %0d", i, wus, exp_w); else n_pass++;
      n_checks++; if (int'(pos) !== exp_p) $display("FAIL nominal_pos[%0d]: got %0d expected %0d", i, pos, exp_p); else n_pass++;
      n_checks++; if (lost !== 1'b0) $display("FAIL nominal_lost[%0d]: got %b expected 0", i, lost); else n_pass++;
    end
  endtask

  task automatic test_mapping;
    int us[3] = '{2000, 2500, 1000};
    int dv, de, edv, ede;
    foreach (us[i]) begin
      model_pulse(us[i] * T, edv, ede);
      drive_pulse(us[i] * T, GAP, dv, de);
      n_checks++; if (dv !== edv) $display("FAIL map_valid[%0d]: got %0d expected %0d", us[i], dv, edv); else n_pass++;
      n_checks++; if (de !== ede) $display("FAIL map_err[%0d]: got %0d expected %0d", us[i], de, ede); else n_pass++;
      n_checks++; if (int'(wus) !== exp_w) $display("FAIL map_width[%0d]: got %0d expected %0d", us[i], wus, exp_w); else n_pass++;
      n_checks++; if (int'(pos) !== exp_p) $display("FAIL map_pos[%0d]: got %0d expected %0d", us[i], pos, exp_p); else n_pass++;
    end
  endtask

  task automatic test_reject;
    int us[3] = '{1200, 300, 2600};
    int dv, de, edv, ede;
    foreach (us[i]) begin
      model_pulse(us[i] * T, edv, ede);
      drive_pulse(us[i] * T, GAP, dv, de);
      n_checks++; if (dv !== edv) $display("FAIL reject_valid[%0d]: got %0d expected %0d", us[i], dv, edv); else n_pass++;
      n_checks++; if (de !== ede) $display("FAIL reject_err[%0d]: got %0d expected %0d", us[i], de, ede); else n_pass++;
      n_checks++; if (int'(wus) !== exp_w) $display("FAIL reject_width[%0d]: got %0d expected %0d", us[i], wus, exp_w); else n_pass++;
      n_checks++; if (int'(pos) !== exp_p) $display("FAIL reject_pos[%0d]: got %0d expected %0d", us[i], pos, exp_p); else n_pass++;
    end
  endtask

  // Cycle-exact edges of the accepted window, including floor rounding
  task automatic test_boundaries;
    int cyc[4] = '{MIN * T - 1, MIN * T, MAX * T + 1, (MAX + 1) * T};
    int dv, de, edv, ede;
    foreach (cyc[i]) begin
      model_pulse(cyc[i], edv, ede);
      drive_pulse(cyc[i], GAP, dv, de);
      n_checks++; if (dv !== edv) $display("FAIL bound_valid[%0d cyc]: got %0d expected %0d", cyc[i], dv, edv); else n_pass++;
      n_checks++; if (de !== ede) $display("FAIL bound_err[%0d cyc]: got %0d expected %0d", cyc[i], de, ede); else n_pass++;
      n_checks++; if (int'(wus) !== exp_w) $display("FAIL bound_width[%0d cyc]: got %0d expected %0d", cyc[i], wus, exp_w); else n_pass++;
      n_checks++; if (int'(pos) !== exp_p) $display("FAIL bound_pos[%0d cyc]: got %0d expected %0d", cyc[i], pos, exp_p); else n_pass++;
    end
  endtask

  task automatic test_lost;
    int dv, de, edv, ede;
    // Valid pulse, then silence; Lost timed from that pulse's rising edge
    model_pulse(1500 * T, edv, ede);
    drive_pulse(1500 * T, (TO - 10 - 1500) * T, dv, de);
    n_checks++; if (dv !== edv) $display("FAIL lost_pre_valid: got %0d expected %0d", dv, edv); else n_pass++;
    n_checks++; if (lost !== 1'b0) $display("FAIL lost_early: got %b expected 0", lost); else n_pass++;
    repeat (20 * T) @(negedge clk);
    n_checks++; if (lost !== 1'b1) $display("FAIL lost_set: got %b expected 1", lost); else n_pass++;
    model_pulse(1500 * T, edv, ede);
    drive_pulse(1500 * T, GAP, dv, de);
    n_checks++; if (dv !== edv) $display("FAIL lost_recover_valid: got %0d expected %0d", dv, edv); else n_pass++;
    n_checks++; if (lost !== 1'b0) $display("FAIL lost_cleared: got %b expected 0", lost); else n_pass++;
    n_checks++; if (int'(wus) !== exp_w) $display("FAIL lost_recover_width: got %0d expected %0d", wus, exp_w); else n_pass++;
  endtask

  // Pulse held past the timeout: Lost rises mid-pulse, then Err, Lost stays
  task automatic test_long_pulse;
    int v0, e0, edv, ede;
    v0 = valid_cnt; e0 = err_cnt;
    model_pulse(2800 * T, edv, ede);
    @(negedge clk) pin = 1'b1;
    repeat (2760 * T) @(negedge clk);
    n_checks++; if (lost !== 1'b1) $display("FAIL long_lost_mid: got %b expected 1", lost); else n_pass++;
    n_checks++; if ((valid_cnt - v0) + (err_cnt - e0) !== 0)
      $display("FAIL long_no_strobe_mid: got %0d expected 0", (valid_cnt - v0) + (err_cnt - e0)); else n_pass++;
    repeat (40 * T) @(negedge clk);
    pin = 1'b0;
    repeat (GAP) @(negedge clk);
    n_checks++; if (err_cnt - e0 !== ede) $display("FAIL long_err: got %0d expected %0d", err_cnt - e0, ede); else n_pass++;
    n_checks++; if (valid_cnt - v0 !== edv) $display("FAIL long_valid: got %0d expected %0d", valid_cnt - v0, edv); else n_pass++;
    n_checks++; if (lost !== 1'b1) $display("FAIL long_lost_after_err: got %b expected 1", lost); else n_pass++;
    n_checks++; if (int'(wus) !== exp_w) $display("FAIL long_width_held: got %0d expected %0d", wus, exp_w); else n_pass++;
  endtask

  task automatic test_reset_high;
    int v0, e0, dv, de, edv, ede;
    @(negedge clk) rst = 1'b1; pin = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (lost !== 1'b0) $display("FAIL rsthigh_lost: got %b expected 0", lost); else n_pass++;
    n_checks++; if (wus !== 12'd0) $display("FAIL rsthigh_width: got %0d expected 0", wus); else n_pass++;
    exp_w = 0; exp_p = 0;
    v0 = valid_cnt; e0 = err_cnt;
    rst = 1'b0;
    repeat (700 * T) @(negedge clk);
    pin = 1'b0;
    repeat (GAP) @(negedge clk);
    n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL rsthigh_no_valid: got %0d expected 0", valid_cnt - v0); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL rsthigh_no_err: got %0d expected 0", err_cnt - e0); else n_pass++;
    model_pulse(1800 * T, edv, ede);
    drive_pulse(1800 * T, GAP, dv, de);
    n_checks++; if (dv !== edv) $display("FAIL rsthigh_next_valid: got %0d expected %0d", dv, edv); else n_pass++;
    n_checks++; if (int'(wus) !== exp_w) $display("FAIL rsthigh_next_width: got %0d expected %0d", wus, exp_w); else n_pass++;
    n_checks++; if (int'(pos) !== exp_p) $display("FAIL rsthigh_next_pos: got %0d expected %0d", pos, exp_p); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int v0, e0, dv, de, edv, ede;
    v0 = valid_cnt; e0 = err_cnt;
    @(negedge clk) pin = 1'b1;
    repeat (400 * T) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (wus !== 12'd0) $display("FAIL rstmid_width: got %0d expected 0", wus); else n_pass++;
    n_checks++; if (pos !== 4'd0)  $display("FAIL rstmid_pos: got %0d expected 0", pos); else n_pass++;
    n_checks++; if (vld !== 1'b0 || err !== 1'b0) $display("FAIL rstmid_strobes: got %b%b expected 00", vld, err); else n_pass++;
    n_checks++; if (lost !== 1'b0) $display("FAIL rstmid_lost: got %b expected 0", lost); else n_pass++;
    exp_w = 0; exp_p = 0;
    rst = 1'b0;
    repeat (1100 * T) @(negedge clk);
    pin = 1'b0;
    repeat (GAP) @(negedge clk);
    n_checks++; if ((valid_cnt - v0) + (err_cnt - e0) !== 0)
      $display("FAIL rstmid_no_strobe: got %0d expected 0", (valid_cnt - v0) + (err_cnt - e0)); else n_pass++;
    model_pulse(1500 * T, edv, ede);
    drive_pulse(1500 * T, GAP, dv, de);
    n_checks++; if (dv !== edv) $display("FAIL rstmid_next_valid: got %0d expected %0d", dv, edv); else n_pass++;
    n_checks++; if (int'(wus) !== exp_w) $display("FAIL rstmid_next_width: got %0d expected %0d", wus, exp_w); else n_pass++;
    n_checks++; if (int'(pos) !== exp_p) $display("FAIL rstmid_next_pos: got %0d expected %0d", pos, exp_p); else n_pass++;
  endtask

  task automatic test_random;
    int hi, dv, de, edv, ede;
    for (int i = 0; i < 3; i++) begin
      hi = $urandom_range(2650 * T, 300 * T);
      model_pulse(hi, edv, ede);
      drive_pulse(hi, GAP, dv, de);
      n_checks++; if (dv !== edv) $display("FAIL rand_valid[%0d cyc]: got %0d expected %0d", hi, dv, edv); else n_pass++;
      n_checks++; if (de !== ede) $display("FAIL rand_err[%0d cyc]: got %0d expected %0d", hi, de, ede); else n_pass++;
      n_checks++; if (int'(wus) !== exp_w) $display("FAIL rand_width[%0d cyc]: got %0d expected %0d", hi, wus, exp_w); else n_pass++;
      n_checks++; if (int'(pos) !== exp_p) $display("FAIL rand_pos[%0d cyc]: got %0d expected %0d", hi, pos, exp_p); else n_pass++;
    end
  endtask

  task automatic test_exclusive;
    n_checks++; if (both_cnt !== 0) $display("FAIL valid_err_overlap: got %0d expected 0", both_cnt); else n_pass++;
    n_checks++; if (lost_with_valid !== 0) $display("FAIL lost_during_valid: got %0d expected 0", lost_with_valid); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_mapping;
    test_reject;
    test_boundaries;
    test_lost;
    test_long_pulse;
    test_reset_high;
    test_reset_mid;
    test_random;
    test_exclusive;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
